// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: decodes E0/F0 prefixes, suppresses typematic
// repeats, counts key presses, tracks the held key and queues key events
// in a first-word-fall-through FIFO drained by a valid/ready consumer.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   rx_valid, rx_data   one-cycle strobe with a received scan-code byte
//   evt_valid/_ready    FIFO head handshake
//   evt_code/_ext/_brk  FIFO head event (held when no event is shown)
//   fifo_count          occupied FIFO entries
//   press_cnt           number of accepted make events (wraps)
//   key_held, held_code, held_ext   currently held key
//   overflow, ovf_clr   sticky dropped-event flag and its clear
//
// Build option: define PS2_BREAK_EVT_EN to also queue break (release)
// events; otherwise breaks only release the held key and evt_brk is 0.
module ps2_key_event_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          rx_valid,
   input  logic [7:0]                    rx_data,
   output logic                          evt_valid,
   output logic [7:0]                    evt_code,
   output logic                          evt_ext,
   output logic                          evt_brk,
   input  logic                          evt_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]              press_cnt,
   output logic                          key_held,
   output logic [7:0]                    held_code,
   output logic                          held_ext,
   output logic                          overflow,
   input  logic                          ovf_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK
   } state_t;

   state_t state, state_nxt;

   logic   is_ctl;
   logic   mk_stb;
   logic   brk_stb;
   logic   ext_cur;
   logic   held_hit;
   logic   new_make;
   logic   push;
   logic   pop;
   logic   full;
   logic   wr_en;
   logic   drop;

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [AW-1:0] wr_idx, rd_idx;

   logic [7:0] mem_code [FIFO_DEPTH];
   logic       mem_ext  [FIFO_DEPTH];
   logic [7:0] last_code;
   logic       last_ext;

   // Controller/status bytes (BAT result, ACK, echo, resend, errors)
   // abort any pending prefix and never produce an event.
   assign is_ctl = rx_data inside {8'h00, 8'hFF, 8'hAA,
                                   8'hFA, 8'hEE, 8'hFE};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mk_stb    = 1'b0;
      brk_stb   = 1'b0;
      ext_cur   = 1'b0;
      if (rx_valid) begin
         if (is_ctl) begin
            state_nxt = S_IDLE;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (rx_data == 8'hE0)      state_nxt = S_EXT;
                  else if (rx_data == 8'hF0) state_nxt = S_BRK;
                  else                       mk_stb    = 1'b1;
               end
               S_EXT: begin
                  if (rx_data == 8'hF0) begin
                     state_nxt = S_EXT_BRK;
                  end else if (rx_data != 8'hE0) begin
                     mk_stb    = 1'b1;
                     ext_cur   = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end
               S_BRK: begin
                  if (rx_data == 8'hE0) begin
                     state_nxt = S_EXT_BRK;
                  end else if (rx_data != 8'hF0) begin
                     brk_stb   = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end
               S_EXT_BRK: begin
                  if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
                     brk_stb   = 1'b1;
                     ext_cur   = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // A make matching the held key is a typematic repeat.
   assign held_hit = key_held && (held_ext == ext_cur) &&
                     (held_code == rx_data);
   assign new_make = mk_stb && !held_hit;

`ifdef PS2_BREAK_EVT_EN
   assign push = new_make || brk_stb;
`else
   assign push = new_make;
`endif

   assign wr_idx     = wr_ptr[AW-1:0];
   assign rd_idx     = rd_ptr[AW-1:0];
   assign fifo_count = wr_ptr - rd_ptr;
   assign evt_valid  = (fifo_count != '0);
   assign full       = (fifo_count == PW'(FIFO_DEPTH));
   assign pop        = evt_valid && evt_ready;
   // A pop on the same edge frees the slot a full-FIFO push needs.
   assign wr_en      = push && (!full || pop);
   assign drop       = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_code[wr_idx] <= rx_data;
         mem_ext[wr_idx]  <= ext_cur;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         last_code <= '0;
         last_ext  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + PW'(1);
            last_code <= mem_code[rd_idx];
            last_ext  <= mem_ext[rd_idx];
         end
      end
   end

   // Head is visible while valid; otherwise the last popped event holds.
   assign evt_code = evt_valid ? mem_code[rd_idx] : last_code;
   assign evt_ext  = evt_valid ? mem_ext[rd_idx]  : last_ext;

`ifdef PS2_BREAK_EVT_EN
   logic mem_brk [FIFO_DEPTH];
   logic last_brk;

   always_ff @(posedge clk) begin
      if (wr_en) mem_brk[wr_idx] <= brk_stb;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)  last_brk <= 1'b0;
      else if (pop) last_brk <= mem_brk[rd_idx];
   end

   assign evt_brk = evt_valid ? mem_brk[rd_idx] : last_brk;
`else
   assign evt_brk = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         press_cnt <= '0;
         key_held  <= 1'b0;
         held_code <= '0;
         held_ext  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (new_make) begin
            press_cnt <= press_cnt + CNT_W'(1);
            key_held  <= 1'b1;
            held_code <= rx_data;
            held_ext  <= ext_cur;
         end else if (brk_stb && held_hit) begin
            key_held  <= 1'b0;
         end
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed table, corner sequences and
// randomized byte streams against a queue-based reference model.
module tb_ps2_key_event_ctrl;

   localparam int DEPTH = 8;
   localparam int CW    = 8;
`ifdef PS2_BREAK_EVT_EN
   localparam bit BE = 1'b1;
`else
   localparam bit BE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_brk;
   logic       evt_ready;
   logic [3:0] fifo_count;
   logic [7:0] press_cnt;
   logic       key_held;
   logic [7:0] held_code;
   logic       held_ext;
   logic       overflow;
   logic       ovf_clr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .resetn(resetn),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .evt_valid(evt_valid), .evt_code(evt_code),
      .evt_ext(evt_ext), .evt_brk(evt_brk),
      .evt_ready(evt_ready), .fifo_count(fifo_count),
      .press_cnt(press_cnt), .key_held(key_held),
      .held_code(held_code), .held_ext(held_ext),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   // Reference model: prefix flags, event queue {ext,brk,code}.
   bit         m_ext, m_brk, m_held, m_he, m_ovf;
   int         m_cnt;
   logic [7:0] m_hc;
   logic [9:0] m_q[$];
   logic [9:0] m_last;

   task automatic m_reset();
      m_ext = 0; m_brk = 0; m_held = 0; m_he = 0; m_ovf = 0;
      m_cnt = 0; m_hc = 0; m_q.delete(); m_last = '0;
   endtask

   task automatic m_step(input bit v, input logic [7:0] d,
                         input bit rdy, input bit clr);
      bit pop, push, drop, hit;
      logic [9:0] ent;
      pop = (m_q.size() > 0) && rdy;
      push = 0; drop = 0; ent = '0;
      if (v) begin
         if (d inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE}) begin
            m_ext = 0; m_brk = 0;
         end else if (d == 8'hE0) begin
            m_ext = 1;
         end else if (d == 8'hF0) begin
            m_brk = 1;
         end else begin
            hit = m_held && (m_he == m_ext) && (m_hc == d);
            if (!m_brk) begin
               if (!hit) begin
                  push = 1; ent = {m_ext, 1'b0, d};
                  m_cnt = (m_cnt + 1) % (1 << CW);
                  m_held = 1; m_hc = d; m_he = m_ext;
               end
            end else begin
               if (hit) m_held = 0;
               if (BE) begin
                  push = 1; ent = {m_ext, 1'b1, d};
               end
            end
            m_ext = 0; m_brk = 0;
         end
      end
      if (pop) m_last = m_q.pop_front();
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(ent);
         else drop = 1;
      end
      if (drop)     m_ovf = 1;
      else if (clr) m_ovf = 0;
   endtask

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_model(input string name);
      logic [9:0] h;
      logic [63:0] g, e;
      h = (m_q.size() > 0) ? m_q[0] : m_last;
      e = {30'd0, (m_q.size() > 0), h, 4'(m_q.size()), 8'(m_cnt),
           m_held, m_hc, m_he, m_ovf};
      g = {30'd0, evt_valid, evt_ext, evt_brk, evt_code, fifo_count,
           press_cnt, key_held, held_code, held_ext, overflow};
      chk(name, g, e);
   endtask

   task automatic cycle(input bit v, input logic [7:0] d,
                        input bit rdy, input bit clr);
      rx_valid = v; rx_data = d; evt_ready = rdy; ovf_clr = clr;
      m_step(v, d, rdy, clr);
      @(posedge clk);
      #1;
      rx_valid = 0; evt_ready = 0; ovf_clr = 0;
   endtask

   task automatic do_reset();
      resetn = 0;
      #2;
      resetn = 1;
      m_reset();
   endtask

   typedef struct {
      bit v; logic [7:0] d; bit rdy;
      bit ev; logic [7:0] code; bit ext; int cnt;
      int pc; bit held; logic [7:0] hc; bit he;
   } vec_t;

   vec_t tbl[21];
   logic [7:0] bytes[11];

   initial begin
      resetn = 0; rx_valid = 0; rx_data = 0; evt_ready = 0; ovf_clr = 0;
      m_reset();
      bytes = '{8'hE0, 8'hF0, 8'h1C, 8'h1D, 8'h75, 8'h6B,
                8'hAA, 8'h00, 8'hF0, 8'hE0, 8'h1C};
      tbl = '{
         '{1, 8'h1C, 0, 1, 8'h1C, 0, 1, 1, 1, 8'h1C, 0},
         '{0, 8'h00, 1, 0, 8'h1C, 0, 0, 1, 1, 8'h1C, 0},
         '{1, 8'h1C, 1, 0, 8'h1C, 0, 0, 1, 1, 8'h1C, 0},
         '{1, 8'hF0, 1, 0, 8'h1C, 0, 0, 1, 1, 8'h1C, 0},
         '{1, 8'h1C, 1, BE, 8'h1C, 0, int'(BE), 1, 0, 8'h1C, 0},
         '{0, 8'h00, 1, 0, 8'h1C, 0, 0, 1, 0, 8'h1C, 0},
         '{1, 8'hE0, 1, 0, 8'h1C, 0, 0, 1, 0, 8'h1C, 0},
         '{1, 8'h75, 0, 1, 8'h75, 1, 1, 2, 1, 8'h75, 1},
         '{1, 8'hE0, 0, 1, 8'h75, 1, 1, 2, 1, 8'h75, 1},
         '{1, 8'hF0, 0, 1, 8'h75, 1, 1, 2, 1, 8'h75, 1},
         '{1, 8'h75, 0, 1, 8'h75, 1, 1 + int'(BE), 2, 0, 8'h75, 1},
         '{0, 8'h00, 1, BE, 8'h75, 1, int'(BE), 2, 0, 8'h75, 1},
         '{0, 8'h00, 1, 0, 8'h75, 1, 0, 2, 0, 8'h75, 1},
         '{1, 8'hF0, 1, 0, 8'h75, 1, 0, 2, 0, 8'h75, 1},
         '{1, 8'hAA, 1, 0, 8'h75, 1, 0, 2, 0, 8'h75, 1},
         '{1, 8'hF0, 1, 0, 8'h75, 1, 0, 2, 0, 8'h75, 1},
         '{1, 8'hFA, 1, 0, 8'h75, 1, 0, 2, 0, 8'h75, 1},
         '{1, 8'hF0, 1, 0, 8'h75, 1, 0, 2, 0, 8'h75, 1},
         '{1, 8'h00, 1, 0, 8'h75, 1, 0, 2, 0, 8'h75, 1},
         '{1, 8'h1C, 1, 1, 8'h1C, 0, 1, 3, 1, 8'h1C, 0},
         '{0, 8'h00, 1, 0, 8'h1C, 0, 0, 3, 1, 8'h1C, 0}
      };

      #13;
      chk("reset_state",
          {evt_valid, evt_code, evt_ext, evt_brk, fifo_count, press_cnt,
           key_held, held_code, held_ext, overflow}, '0);
      resetn = 1;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].rdy, 0);
         chk($sformatf("table_%0d", i),
             {evt_valid, evt_code, evt_ext, fifo_count, press_cnt,
              key_held, held_code, held_ext},
             {tbl[i].ev, tbl[i].code, tbl[i].ext, 4'(tbl[i].cnt),
              8'(tbl[i].pc), tbl[i].held, tbl[i].hc, tbl[i].he});
      end
      check_model("table_model");

      // Overflow: nine distinct makes into an 8-entry FIFO.
      do_reset();
      for (int i = 0; i < 9; i++) cycle(1, 8'h15 + 8'(i), 0, 0);
      chk("ovf_count", 64'(fifo_count), 64'd8);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_press", 64'(press_cnt), 64'd9);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_%0d", i), {evt_valid, evt_code},
             {1'b1, 8'h15 + 8'(i)});
         cycle(0, 0, 1, 0);
      end
      chk("drain_empty", {evt_valid, evt_code, fifo_count},
          {1'b0, 8'h1C, 4'd0});
      chk("ovf_sticky", 64'(overflow), 64'd1);
      cycle(0, 0, 0, 1);
      chk("ovf_clr", 64'(overflow), 64'd0);

      // Full FIFO with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 8'h20 + 8'(i), 0, 0);
      cycle(1, 8'h28, 1, 0);
      chk("full_pushpop", {fifo_count, overflow, evt_code},
          {4'd8, 1'b0, 8'h21});
      check_model("full_pushpop_model");
      // Drop and clear on the same edge: set wins.
      cycle(1, 8'h29, 0, 1);
      chk("ovf_set_wins", 64'(overflow), 64'd1);

      // Reset mid-prefix discards the E0.
      do_reset();
      cycle(1, 8'hE0, 0, 0);
      do_reset();
      cycle(1, 8'h75, 0, 0);
      chk("rst_prefix", {evt_valid, evt_code, evt_ext, press_cnt},
          {1'b1, 8'h75, 1'b0, 8'd1});

      // Randomized byte streams.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) != 0,
               bytes[$urandom_range(0, 10)],
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 15) == 0);
         check_model($sformatf("rand_%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sequencer between the PS/2 byte receiver and display/consumer logic.
- Decodes the raw scan-code byte stream: E0 extended prefix, F0 break prefix, typematic-repeat suppression.
- Counts distinct key presses and tracks the currently held key.
- Queues decoded key events in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the press counter.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe; rx_data holds a complete, parity-checked byte.
- rx_data  in  8  received scan-code byte.
- evt_valid  out  1  FIFO head holds an event.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event was E0-prefixed.
- evt_brk  out  1  head event is a release.
- evt_ready  in  1  consumer accepts the head event.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- press_cnt  out  CNT_W  count of accepted make events.
- key_held  out  1  a key is currently held.
- held_code  out  8  code of the held key.
- held_ext  out  1  extended flag of the held key.
- overflow  out  1  sticky flag: an event was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset: async on resetn low.
  - FSM to S_IDLE, FIFO emptied (evt_valid=0, fifo_count=0).
  - evt_code/evt_ext/evt_brk=0, press_cnt=0, key_held=0, held_code=0, held_ext=0, overflow=0.
  - A prefix already received is discarded.
- FSM: states S_IDLE, S_EXT, S_BRK, S_EXT_BRK. Acts only when rx_valid=1.
  - S_IDLE:
    - E0 -> S_EXT.
    - F0 -> S_BRK.
    - other byte c -> make(c, ext=0), stay S_IDLE.
  - S_EXT:
    - F0 -> S_EXT_BRK.
    - E0 -> stay S_EXT.
    - c -> make(c, ext=1), go to S_IDLE.
  - S_BRK:
    - F0 -> stay S_BRK.
    - E0 -> S_EXT_BRK.
    - c -> break(c, ext=0), go to S_IDLE.
  - S_EXT_BRK:
    - E0/F0 -> stay S_EXT_BRK.
    - c -> break(c, ext=1), go to S_IDLE.
  - Bytes 00, FF, AA, FA, EE, FE in any state: no event, FSM returns to S_IDLE.
- Make handling:
  - If key_held=1 and {ext,c}=={held_ext,held_code}: typematic repeat, suppressed. No push, no count.
  - Otherwise:
    - push {ext,0,c};
    - press_cnt+1, wrapping from 2^CNT_W-1 to 0;
    - held_code/held_ext <= c/ext, key_held <= 1.
- Break handling:
  - If {ext,c} matches the held key: key_held <= 0.
  - held_code/held_ext keep their last value.
  - Break-event push is governed by the Optional Feature.
- Latency: with rx_valid at edge N, FSM, counter, held key and FIFO all update at edge N. evt_valid and fifo_count reflect the new event after edge N.
- FIFO:
  - FWFT: evt_* show the head entry whenever evt_valid=1.
  - Pop on the edge where evt_valid & evt_ready.
  - evt_* outputs hold when evt_valid=0 or evt_ready=0.
  - When the FIFO empties, evt_* keep the last value and evt_valid=0.
- Boundary conditions:
  - Push while full with no pop: event dropped, overflow <= 1. press_cnt and the held key still update.
  - Push and pop on the same edge while full: both accepted, count unchanged.
  - Push while empty: pop impossible that cycle because evt_valid=0.
  - Pointer wrap modulo FIFO_DEPTH.
- overflow: cleared by ovf_clr. If a drop and ovf_clr occur on the same edge, set wins.

Optional Feature:
- Macro: PS2_BREAK_EVT_EN.
- Defined:
  - Break events are pushed as {ext,1,c}.
  - Breaks of non-held keys are also pushed.
  - Overflow rules apply equally to break pushes.
- Undefined:
  - Breaks only update key_held and are never pushed.
  - evt_brk is tied 0.

Test Plan:
- Byte 1C -> one event {code 1C, ext 0, brk 0}; evt_valid=1 the cycle after; press_cnt=1; key_held=1; held_code=1C.
- Bytes 1C,1C,1C,F0,1C with evt_ready=1 -> one make event, plus one break event (brk=1) only if PS2_BREAK_EVT_EN; press_cnt=1; key_held=0.
- Bytes E0,75,E0,F0,75 -> make {75, ext 1}, then break {75, ext 1} if PS2_BREAK_EVT_EN; press_cnt=1; FSM ends in S_IDLE.
- evt_ready=0, makes 15,16,...,1D (9 distinct codes) -> fifo_count=8, overflow=1; draining yields 15..1C in order; press_cnt=9.
- Bytes E0 then resetn pulse low mid-sequence, then 75 -> event {75, ext 0}; press_cnt=1.
- Interleaved bytes AA, FA, 00 while in S_BRK -> no events; next 1C produces a make, not a break.
